// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: steps each instruction through fetch/decode/execute
// states and drives datapath enables, mux selects and aluop, with mem_ready wait states.
module mc_maindec #(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned STATE_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       pcen,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMS2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_RTYPEEX = STATE_W'(6),
    S_RTYPEWB = STATE_W'(7),
    S_BEQEX   = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JEX     = STATE_W'(11)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ready;
  logic       w_op_known;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;
  logic       w_iord;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [1:0] w_aluop;

  assign w_mem_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  assign w_op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BEQEX:   w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JEX:     w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore output decode; only the FETCH/MEMWR strobes follow mem_ready.
  always_comb begin
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_iord     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = SRCB_RT;
    w_pcsrc    = PCSRC_ALU;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = SRCB_FOUR;
        w_irwrite = w_mem_ready;
        w_pcwrite = w_mem_ready;
      end
      S_DECODE: begin
        w_alusrcb = SRCB_IMMS2;
        w_illegal = !w_op_known;
      end
      S_MEMADR, S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
      end
      S_MEMRD: w_iord = 1'b1;
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = w_mem_ready;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_branch  = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc   = PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: w_alusrcb = SRCB_RT;
    endcase
  end

  // Write strobes are held off while reset_n is low; state is already FETCH then.
  assign irwrite    = reset_n & w_irwrite;
  assign pcen       = reset_n & (w_pcwrite | (w_branch & zero));
  assign memwrite   = reset_n & w_memwrite;
  assign regwrite   = reset_n & w_regwrite;
  assign illegal_op = reset_n & w_illegal;
  assign iord       = w_iord;
  assign regdst     = w_regdst;
  assign memtoreg   = w_memtoreg;
  assign alusrca    = w_alusrca;
  assign alusrcb    = w_alusrcb;
  assign pcsrc      = w_pcsrc;
  assign aluop      = w_aluop;

endmodule
